// File: rtl/chinx_mem_pkg.sv
// Shared types and constants for the chinx memory-port arbiter.
package chinx_mem_pkg;

  // Owner of an outstanding memory read.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2
  } mem_tag_t;

  // Default bound on consecutive data grants while fetch is waiting.
  localparam int MAX_DATA_RUN_DEF = 2;

  // Operand-size encodings on the memory port.
  localparam logic [1:0] MEM_OPND_BYTE = 2'd0;
  localparam logic [1:0] MEM_OPND_HALF = 2'd1;
  localparam logic [1:0] MEM_OPND_WORD = 2'd2;

endpackage

// File: rtl/chinx_resp_pipe.sv
// Two-stage owner-tag pipeline that lines up read responses with their requester.
// A fetch kill (branch flush) removes fetch tags from both stages.
module chinx_resp_pipe
  import chinx_mem_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  mem_tag_t push_tag,
  input  logic     kill_fetch,
  output mem_tag_t out_tag
);

  mem_tag_t stage0_q;
  mem_tag_t stage1_q;

  // Advance tags one stage per cycle, dropping fetch tags when killed.
  // NOTE: registers use non-blocking assignments so stage1 samples the pre-edge stage0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage0_q <= TAG_NONE;
      stage1_q <= TAG_NONE;
    end else begin
      stage0_q <= (kill_fetch && push_tag == TAG_FETCH) ? TAG_NONE : push_tag;
      stage1_q <= (kill_fetch && stage0_q == TAG_FETCH) ? TAG_NONE : stage0_q;
    end
  end

  assign out_tag = stage1_q;

endmodule

// File: rtl/chinx_mem_arbiter.sv
// Shares one synchronous memory port between instruction fetch and the
// stage2 load/store path. Data wins ties, except when fetch has already
// waited MAX_DATA_RUN consecutive data grants.
module chinx_mem_arbiter
  import chinx_mem_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int OPND_W       = 2,
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [OPND_W-1:0] d_opnd_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [OPND_W-1:0] mem_opnd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  logic [RUN_W-1:0] run_cnt_q;
  logic             f_want;
  logic             grant_f;
  logic             grant_d;
  mem_tag_t         push_tag;
  mem_tag_t         resp_tag;

  // A flushed fetch cannot compete this cycle.
  assign f_want = f_req_i & ~flush_i;

  // Pick this cycle's winner and the owner tag it launches into the response pipe.
  // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    grant_f  = 1'b0;
    grant_d  = 1'b0;
    push_tag = TAG_NONE;
    if (rst) begin
      if (f_want && d_req_i) begin
        if (run_cnt_q == RUN_MAX) grant_f = 1'b1;
        else                      grant_d = 1'b1;
      end else if (f_want) begin
        grant_f = 1'b1;
      end else if (d_req_i) begin
        grant_d = 1'b1;
      end
    end
    if (grant_f)                 push_tag = TAG_FETCH;
    else if (grant_d && !d_we_i) push_tag = TAG_DATA;
  end

  // Count consecutive data grants that made a waiting fetch lose.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q <= '0;
    end else if (grant_f || !f_req_i) begin
      run_cnt_q <= '0;
    end else if (grant_d && run_cnt_q != RUN_MAX) begin
      run_cnt_q <= run_cnt_q + RUN_W'(1);
    end
  end

  // Register the granted command onto the memory port; fields hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_opnd_o  <= OPND_W'(MEM_OPND_WORD);
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_en_o <= grant_f | grant_d;
      if (grant_d) begin
        mem_we_o    <= d_we_i;
        mem_opnd_o  <= d_opnd_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
      end else if (grant_f) begin
        mem_we_o    <= 1'b0;
        mem_opnd_o  <= OPND_W'(MEM_OPND_WORD);
        mem_addr_o  <= f_addr_i;
        mem_wdata_o <= '0;
      end
    end
  end

  chinx_resp_pipe u_resp_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_tag   (push_tag),
    .kill_fetch (flush_i),
    .out_tag    (resp_tag)
  );

  assign f_gnt_o    = grant_f;
  assign d_gnt_o    = grant_d;
  assign stall_o    = rst & f_want & ~grant_f;
  assign f_rvalid_o = (resp_tag == TAG_FETCH);
  assign d_rvalid_o = (resp_tag == TAG_DATA);
  assign rdata_o    = (resp_tag == TAG_NONE) ? '0 : mem_rdata_i;

endmodule

// File: tb/tb_chinx_mem_arbiter.sv
// Directed bench for chinx_mem_arbiter with a response scoreboard.
module tb_chinx_mem_arbiter;
  import chinx_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        f_req_i;
  logic [7:0]  f_addr_i;
  logic        f_gnt_o;
  logic        f_rvalid_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [1:0]  d_opnd_i;
  logic [7:0]  d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] rdata_o;
  logic        flush_i;
  logic        stall_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [1:0]  mem_opnd_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  // Expected response: owner as {f_rvalid, d_rvalid} plus read data.
  typedef struct packed {
    logic [1:0]  fd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_img [256];

  chinx_mem_arbiter #(
    .ADDR_W(8), .DATA_W(32), .OPND_W(2), .MAX_DATA_RUN(2)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o), .f_rvalid_o(f_rvalid_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_opnd_i(d_opnd_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .rdata_o(rdata_o),
    .flush_i(flush_i), .stall_o(stall_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_opnd_o(mem_opnd_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memory model: read data appears the cycle after mem_en_o.
  always @(posedge clk) begin
    if (!rst) begin
      mem_rdata_i       <= 32'h0;
      mem_img[8'h10]    <= 32'hA5A5_0001;
      mem_img[8'h30]    <= 32'h3030_3030;
      mem_img[8'h40]    <= 32'hF000_0040;
      mem_img[8'h80]    <= 32'hD000_0080;
    end else if (mem_en_o) begin
      if (mem_we_o) mem_img[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i         <= mem_img[mem_addr_o];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] fd, input logic [31:0] data);
    exp_t e;
    e.fd   = fd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    f_req_i = 1'b0;
    d_req_i = 1'b0;
    d_we_i  = 1'b0;
    flush_i = 1'b0;
  endtask

  // Monitor: pop the scoreboard whenever a response is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (f_rvalid_o || d_rvalid_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got f=%b d=%b rdata=%h expected no response",
                   f_rvalid_o, d_rvalid_o, rdata_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_owner", {30'b0, f_rvalid_o, d_rvalid_o}, {30'b0, e.fd});
          check("rsp_data", rdata_o, e.data);
        end
      end else begin
        check("idle_rdata", rdata_o, 32'h0);
      end
    end
  end

  initial begin
    logic [5:0] f_pat;
    logic       exp_f;
    rst = 1'b0; idle();
    f_addr_i = 8'h0; d_addr_i = 8'h0; d_opnd_i = MEM_OPND_WORD; d_wdata_i = 32'h0;
    f_req_i = 1'b1;
    repeat (2) cyc();
    check("rst_mem_en", mem_en_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_mem_opnd", mem_opnd_o, MEM_OPND_WORD);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    check("rst_f_gnt", f_gnt_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_rvalid", {f_rvalid_o, d_rvalid_o}, 0);
    f_req_i = 1'b0;
    rst = 1'b1;
    cyc();

    // Lone fetch: grant N, command N+1, data N+2.
    f_req_i = 1'b1; f_addr_i = 8'h10;
    sample();
    check("t1_f_gnt", f_gnt_o, 1);
    check("t1_d_gnt", d_gnt_o, 0);
    check("t1_stall", stall_o, 0);
    push_exp(2'b10, 32'hA5A5_0001);
    cyc(); idle();
    check("t1_mem_en", mem_en_o, 1);
    check("t1_mem_addr", mem_addr_o, 8'h10);
    check("t1_mem_we", mem_we_o, 0);
    check("t1_mem_opnd", mem_opnd_o, MEM_OPND_WORD);
    cyc();
    check("t1_mem_en_off", mem_en_o, 0);
    cyc();

    // Both requesting every cycle: D,D,F,D,D,F.
    f_pat = 6'b100100;
    f_req_i = 1'b1; f_addr_i = 8'h40;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 8'h80; d_opnd_i = MEM_OPND_WORD;
    for (int i = 0; i < 6; i++) begin
      sample();
      exp_f = f_pat[i];
      check("t2_f_gnt", f_gnt_o, exp_f);
      check("t2_d_gnt", d_gnt_o, !exp_f);
      check("t2_stall", stall_o, !exp_f);
      if (exp_f) push_exp(2'b10, 32'hF000_0040);
      else       push_exp(2'b01, 32'hD000_0080);
      cyc();
    end
    idle();
    repeat (3) cyc();

    // Byte store: write command, no response; then read it back.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 8'h20; d_wdata_i = 32'hDEAD_BEEF;
    d_opnd_i = MEM_OPND_BYTE;
    sample();
    check("t3_d_gnt", d_gnt_o, 1);
    cyc(); idle();
    check("t3_mem_en", mem_en_o, 1);
    check("t3_mem_we", mem_we_o, 1);
    check("t3_mem_addr", mem_addr_o, 8'h20);
    check("t3_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    check("t3_mem_opnd", mem_opnd_o, MEM_OPND_BYTE);
    cyc();
    sample();
    check("t3_no_d_rvalid", d_rvalid_o, 0);
    cyc();
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 8'h20; d_opnd_i = MEM_OPND_WORD;
    sample();
    check("t3_rd_gnt", d_gnt_o, 1);
    push_exp(2'b01, 32'hDEAD_BEEF);
    cyc(); idle();
    repeat (3) cyc();

    // Fetch granted, then flushed while a data load proceeds.
    f_req_i = 1'b1; f_addr_i = 8'h30;
    sample();
    check("t4_f_gnt", f_gnt_o, 1);
    cyc();
    flush_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 8'h80;
    sample();
    check("t4_flush_f_gnt", f_gnt_o, 0);
    check("t4_flush_d_gnt", d_gnt_o, 1);
    check("t4_flush_stall", stall_o, 0);
    push_exp(2'b01, 32'hD000_0080);
    cyc(); idle();
    sample();
    check("t4_no_f_rvalid", f_rvalid_o, 0);
    repeat (3) cyc();

    // Flush with only a fetch request: nothing granted, no stall, no command.
    f_req_i = 1'b1; f_addr_i = 8'h10; flush_i = 1'b1;
    sample();
    check("t6_f_gnt", f_gnt_o, 0);
    check("t6_d_gnt", d_gnt_o, 0);
    check("t6_stall", stall_o, 0);
    cyc(); idle();
    check("t6_mem_en", mem_en_o, 0);
    cyc();

    // Reset while a load is on the memory port: response discarded.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 8'h80;
    sample();
    check("t5_d_gnt", d_gnt_o, 1);
    cyc(); idle();
    check("t5_mem_en_pre", mem_en_o, 1);
    f_req_i = 1'b1;
    rst = 1'b0;
    #1;
    check("t5_mem_en_rst", mem_en_o, 0);
    check("t5_mem_addr_rst", mem_addr_o, 0);
    check("t5_f_gnt_rst", f_gnt_o, 0);
    check("t5_stall_rst", stall_o, 0);
    cyc();
    check("t5_no_rvalid", {f_rvalid_o, d_rvalid_o}, 0);
    f_req_i = 1'b0;
    rst = 1'b1;
    repeat (2) cyc();
    f_req_i = 1'b1; f_addr_i = 8'h10;
    sample();
    check("t5_post_f_gnt", f_gnt_o, 1);
    push_exp(2'b10, 32'hA5A5_0001);
    cyc(); idle();

    for (int i = 0; i < 10 && sb.size() != 0; i++) cyc();
    cyc();
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
